// File: rtl/fpu_acc_if.sv
// Bundle of upstream element, fpu_adder stb/ack and downstream sum signals for fpu_acc_driver.
// master is the accumulator driver's view; slave is the surrounding system's view.
interface fpu_acc_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_stb;
    logic        add_ack;
    logic [31:0] add_z;
    logic        add_z_stb;
    logic        add_z_ack;
    logic        sum_valid;
    logic [31:0] sum_data;
    logic        sum_ready;

    modport master (
        input  in_valid, in_data, in_last, add_ack, add_z, add_z_stb, sum_ready,
        output in_ready, add_a, add_b, add_stb, add_z_ack, sum_valid, sum_data
    );

    modport slave (
        output in_valid, in_data, in_last, add_ack, add_z, add_z_stb, sum_ready,
        input  in_ready, add_a, add_b, add_stb, add_z_ack, sum_valid, sum_data
    );
endinterface

// File: rtl/fpu_acc_driver.sv
// Sums vectors of IEEE-754 singles by driving an external fpu_adder over its stb/ack protocol.
// Optional macro FPU_ACC_SKIP_ZERO_EN: non-first +/-0 elements bypass the adder.
//
// state    | meaning
// ACCEPT   | in_ready high; first element loads acc, later ones are queued for the adder
// WAIT_ACK | operands held on add_a/add_b, waiting for adder input_ack
// ISSUE    | single-cycle add_stb pulse
// WAIT_Z   | waiting for adder result; add_z_ack mirrors add_z_stb
// DONE     | sum_valid high with acc on sum_data until sum_ready
module fpu_acc_driver (
    input  logic      clk,
    input  logic      rst,
    fpu_acc_if.master bus
);
    typedef enum logic [2:0] {ACCEPT, WAIT_ACK, ISSUE, WAIT_Z, DONE} state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        skip_zero;

`ifdef FPU_ACC_SKIP_ZERO_EN
    // Adding a signed zero never changes a nonzero acc, so skip the round trip.
    assign skip_zero = (bus.in_data[30:0] == 31'd0);
`else
    assign skip_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACCEPT;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            acc_q   <= 32'd0;
            opnd_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        unique case (state_q)
            ACCEPT: begin
                if (bus.in_valid) begin
                    if (first_q) begin
                        acc_d   = bus.in_data;
                        first_d = 1'b0;
                        if (bus.in_last) state_d = DONE;
                    end else if (skip_zero) begin
                        if (bus.in_last) state_d = DONE;
                    end else begin
                        opnd_d  = bus.in_data;
                        last_d  = bus.in_last;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.add_ack) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_Z;
            end
            WAIT_Z: begin
                if (bus.add_z_stb) begin
                    acc_d   = bus.add_z;
                    state_d = last_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                if (bus.sum_ready) begin
                    first_d = 1'b1;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    assign bus.in_ready  = (state_q == ACCEPT);
    assign bus.add_a     = acc_q;
    assign bus.add_b     = opnd_q;
    assign bus.add_stb   = (state_q == ISSUE);
    assign bus.add_z_ack = (state_q == WAIT_Z) && bus.add_z_stb;
    assign bus.sum_valid = (state_q == DONE);
    assign bus.sum_data  = acc_q;
endmodule
